// File: rtl/controlador_vendas.sv
// Priced vending sequencer: accumulates coded coins as 25-cent credit units, sells one of
// four items over a req/ack handshake and refunds the remainder as alternating change pulses.
module controlador_vendas #(
    parameter int PRICE0         = 6,
    parameter int PRICE1         = 4,
    parameter int PRICE2         = 3,
    parameter int PRICE3         = 5,
    parameter int MAX_CREDIT     = 12,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       coin_valid,
    input  logic       A,
    input  logic       B,
    input  logic       sel_valid,
    input  logic [1:0] sel,
    input  logic       cancel,
    input  logic       disp_ack,
    output logic [3:0] credit,
    output logic       disp_req,
    output logic [1:0] disp_item,
    output logic       change_pulse,
    output logic       coin_reject,
    output logic       sel_denied,
    output logic       busy
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, CREDIT, DISPENSE, CHANGE} state_t;

    state_t        state_q, state_d;
    logic [3:0]    credit_q, credit_d;
    logic          disp_req_q, disp_req_d;
    logic [1:0]    disp_item_q, disp_item_d;
    logic          change_pulse_q, change_pulse_d;
    logic          coin_reject_q, coin_reject_d;
    logic          sel_denied_q, sel_denied_d;
    logic          busy_q, busy_d;
    logic [TW-1:0] timer_q, timer_d;

    logic [3:0]    coin_value;
    logic [4:0]    coin_sum;
    logic [3:0]    price_sel;
    logic [TW-1:0] timer_inc;
    logic          coin_fits;
    logic          refund;

    always_comb begin
        case ({A, B})
            2'b01:   coin_value = 4'd1;
            2'b10:   coin_value = 4'd2;
            2'b11:   coin_value = 4'd4;
            default: coin_value = 4'd0;
        endcase
        case (sel)
            2'd0:    price_sel = 4'(PRICE0);
            2'd1:    price_sel = 4'(PRICE1);
            2'd2:    price_sel = 4'(PRICE2);
            default: price_sel = 4'(PRICE3);
        endcase
    end

    assign coin_sum  = {1'b0, credit_q} + {1'b0, coin_value};
    assign coin_fits = (coin_value != 4'd0) && (coin_sum <= 5'(MAX_CREDIT));
    assign timer_inc = timer_q + 1'b1;
    // Any coin or selection restarts the idle count, so it can only time out when quiet.
    assign refund    = (state_q == CREDIT) &&
                       (cancel || (!coin_valid && !sel_valid && timer_inc == TW'(TIMEOUT_CYCLES - 1)));

    always_comb begin
        state_d        = state_q;
        credit_d       = credit_q;
        disp_req_d     = disp_req_q;
        disp_item_d    = disp_item_q;
        change_pulse_d = 1'b0;
        coin_reject_d  = 1'b0;
        sel_denied_d   = 1'b0;
        timer_d        = (coin_valid || sel_valid) ? '0 : timer_inc;

        case (state_q)
            IDLE, CREDIT: begin
                coin_reject_d = coin_valid && (refund || sel_valid || cancel || !coin_fits);
                if (refund) begin
                    state_d        = CHANGE;
                    change_pulse_d = 1'b1;
                    credit_d       = credit_q - 4'd1;
                end else if (sel_valid) begin
                    if (credit_q >= price_sel) begin
                        state_d     = DISPENSE;
                        credit_d    = credit_q - price_sel;
                        disp_req_d  = 1'b1;
                        disp_item_d = sel;
                    end else begin
                        sel_denied_d = 1'b1;
                    end
                end else if (coin_valid && !cancel && coin_fits) begin
                    state_d  = CREDIT;
                    credit_d = coin_sum[3:0];
                end
            end
            DISPENSE: begin
                coin_reject_d = coin_valid;
                if (disp_ack) begin
                    disp_req_d = 1'b0;
                    if (credit_q != 4'd0) begin
                        state_d        = CHANGE;
                        change_pulse_d = 1'b1;
                        credit_d       = credit_q - 4'd1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                coin_reject_d = coin_valid;
                // The unit is taken off in the same cycle its pulse is shown.
                if (change_pulse_q) begin
                    if (credit_q == 4'd0) state_d = IDLE;
                end else begin
                    change_pulse_d = 1'b1;
                    credit_d       = credit_q - 4'd1;
                end
            end
        endcase

        if (state_d != CREDIT) timer_d = '0;
        busy_d = (state_d == DISPENSE) || (state_d == CHANGE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            credit_q       <= 4'd0;
            disp_req_q     <= 1'b0;
            disp_item_q    <= 2'd0;
            change_pulse_q <= 1'b0;
            coin_reject_q  <= 1'b0;
            sel_denied_q   <= 1'b0;
            busy_q         <= 1'b0;
            timer_q        <= '0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            disp_req_q     <= disp_req_d;
            disp_item_q    <= disp_item_d;
            change_pulse_q <= change_pulse_d;
            coin_reject_q  <= coin_reject_d;
            sel_denied_q   <= sel_denied_d;
            busy_q         <= busy_d;
            timer_q        <= timer_d;
        end
    end

    assign credit       = credit_q;
    assign disp_req     = disp_req_q;
    assign disp_item    = disp_item_q;
    assign change_pulse = change_pulse_q;
    assign coin_reject  = coin_reject_q;
    assign sel_denied   = sel_denied_q;
    assign busy         = busy_q;
endmodule

// File: tb/tb_controlador_vendas.sv
// Directed scoreboard bench for controlador_vendas: each step pushes the output vector expected
// one cycle later, then pops and compares it against the DUT after the clock edge.
module tb_controlador_vendas;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       coin_valid = 1'b0, A = 1'b0, B = 1'b0, sel_valid = 1'b0;
    logic [1:0] sel = 2'd0;
    logic       cancel = 1'b0, disp_ack = 1'b0;
    logic [3:0] credit;
    logic       disp_req, change_pulse, coin_reject, sel_denied, busy;
    logic [1:0] disp_item;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        string      tag;
        logic [10:0] exp;
    } sb_t;
    sb_t sb_q[$];

    // stimulus bits: [7] coin_valid [6:5] {A,B} [4] sel_valid [3:2] sel [1] cancel [0] disp_ack
    localparam logic [7:0] NOP = 8'h00;
    localparam logic [7:0] CAN = 8'h02;
    localparam logic [7:0] ACK = 8'h01;

    controlador_vendas dut (
        .clock(clock), .reset(reset), .coin_valid(coin_valid), .A(A), .B(B),
        .sel_valid(sel_valid), .sel(sel), .cancel(cancel), .disp_ack(disp_ack),
        .credit(credit), .disp_req(disp_req), .disp_item(disp_item),
        .change_pulse(change_pulse), .coin_reject(coin_reject),
        .sel_denied(sel_denied), .busy(busy)
    );

    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] coin(input logic [1:0] code);
        return {1'b1, code, 5'b0};
    endfunction

    function automatic logic [7:0] pick(input logic [1:0] s);
        return {3'b000, 1'b1, s, 2'b00};
    endfunction

    // expected vector: {credit, disp_req, disp_item, change_pulse, coin_reject, sel_denied, busy}
    function automatic logic [10:0] ev(input int cr, input bit req, input int item,
                                       input bit pul, input bit rej, input bit den, input bit bsy);
        return {4'(cr), req, 2'(item), pul, rej, den, bsy};
    endfunction

    function automatic logic [10:0] observed();
        return {credit, disp_req, disp_item, change_pulse, coin_reject, sel_denied, busy};
    endfunction

    task automatic compare(input string tag, input logic [10:0] exp);
        logic [10:0] mask;
        logic [10:0] obs;
        // disp_item is only meaningful while a dispense request is expected
        mask = exp[6] ? 11'h7FF : 11'h7CF;
        obs  = observed();
        vectors++;
        assert ((obs & mask) === (exp & mask)) else begin
            miscompares++;
            $error("FAIL %s: observed cr=%0d req=%b item=%0d pul=%b rej=%b den=%b busy=%b, expected cr=%0d req=%b item=%0d pul=%b rej=%b den=%b busy=%b",
                   tag, obs[10:7], obs[6], obs[5:4], obs[3], obs[2], obs[1], obs[0],
                   exp[10:7], exp[6], exp[5:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic step(input string tag, input logic [7:0] stim, input logic [10:0] exp);
        sb_t e;
        coin_valid = stim[7];
        {A, B}     = stim[6:5];
        sel_valid  = stim[4];
        sel        = stim[3:2];
        cancel     = stim[1];
        disp_ack   = stim[0];
        sb_q.push_back('{tag, exp});
        @(posedge clock);
        #1;
        {coin_valid, A, B, sel_valid, sel, cancel, disp_ack} = '0;
        e = sb_q.pop_front();
        compare(e.tag, e.exp);
    endtask

    // k change units triggered by first_stim: pulse on alternate cycles, then IDLE
    task automatic drain(input string tag, input int k, input logic [7:0] first_stim);
        for (int i = k - 1; i >= 0; i--) begin
            step(tag, (i == k - 1) ? first_stim : NOP, ev(i, 0, 0, 1, 0, 0, 1));
            if (i > 0) step(tag, NOP, ev(i, 0, 0, 0, 0, 0, 1));
        end
        step({tag, "_idle"}, NOP, ev(0, 0, 0, 0, 0, 0, 0));
    endtask

    initial begin
        #1 reset = 1'b0;
        #1 compare("reset_state", ev(0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(negedge clock);
        reset = 1'b1;

        // sale with one unit of change
        step("t1_c50a", coin(2'b10), ev(2, 0, 0, 0, 0, 0, 0));
        step("t1_c50b", coin(2'b10), ev(4, 0, 0, 0, 0, 0, 0));
        step("t1_c25",  coin(2'b01), ev(5, 0, 0, 0, 0, 0, 0));
        step("t1_sel1", pick(2'd1),  ev(1, 1, 1, 0, 0, 0, 1));
        step("t1_hold", NOP,         ev(1, 1, 1, 0, 0, 0, 1));
        step("t1_hold", NOP,         ev(1, 1, 1, 0, 0, 0, 1));
        drain("t1_chg", 1, ACK);

        // ceiling and invalid code
        step("t2_c100a", coin(2'b11), ev(4, 0, 0, 0, 0, 0, 0));
        step("t2_c100b", coin(2'b11), ev(8, 0, 0, 0, 0, 0, 0));
        step("t2_c100c", coin(2'b11), ev(12, 0, 0, 0, 0, 0, 0));
        step("t2_ovf",   coin(2'b01), ev(12, 0, 0, 0, 1, 0, 0));
        step("t2_code0", coin(2'b00), ev(12, 0, 0, 0, 1, 0, 0));
        step("t2_quiet", NOP,         ev(12, 0, 0, 0, 0, 0, 0));
        drain("t2_chg", 12, CAN);

        // denied selection then cancel refund
        step("t3_c50",  coin(2'b10), ev(2, 0, 0, 0, 0, 0, 0));
        step("t3_sel0", pick(2'd0),  ev(2, 0, 0, 0, 0, 1, 0));
        step("t3_quiet", NOP,        ev(2, 0, 0, 0, 0, 0, 0));
        drain("t3_chg", 2, CAN);

        // coin and selection together: selection wins, coin rejected, zero change
        step("t4_c50", coin(2'b10), ev(2, 0, 0, 0, 0, 0, 0));
        step("t4_c25", coin(2'b01), ev(3, 0, 0, 0, 0, 0, 0));
        step("t4_both", coin(2'b10) | pick(2'd2), ev(0, 1, 2, 0, 1, 0, 1));
        step("t4_hold", NOP, ev(0, 1, 2, 0, 0, 0, 1));
        step("t4_ack",  ACK, ev(0, 0, 0, 0, 0, 0, 0));
        step("t4_idle", NOP, ev(0, 0, 0, 0, 0, 0, 0));

        // inactivity refund of 3 units, coin and selection during CHANGE
        step("t5_c50", coin(2'b10), ev(2, 0, 0, 0, 0, 0, 0));
        step("t5_c25", coin(2'b01), ev(3, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 998; i++) step("t5_wait", NOP, ev(3, 0, 0, 0, 0, 0, 0));
        step("t5_to",     NOP,         ev(2, 0, 0, 1, 0, 0, 1));
        step("t5_coin",   coin(2'b01), ev(2, 0, 0, 0, 1, 0, 1));
        step("t5_p2",     NOP,         ev(1, 0, 0, 1, 0, 0, 1));
        step("t5_sel",    pick(2'd0),  ev(1, 0, 0, 0, 0, 0, 1));
        step("t5_p3",     NOP,         ev(0, 0, 0, 1, 0, 0, 1));
        step("t5_idle",   NOP,         ev(0, 0, 0, 0, 0, 0, 0));

        // cancel and coin ignored/rejected while dispensing
        step("t5_c100", coin(2'b11), ev(4, 0, 0, 0, 0, 0, 0));
        step("t5_sel2", pick(2'd2),  ev(1, 1, 2, 0, 0, 0, 1));
        step("t5_dcan", CAN,         ev(1, 1, 2, 0, 0, 0, 1));
        step("t5_dcoin", coin(2'b10), ev(1, 1, 2, 0, 1, 0, 1));
        drain("t5_chg", 1, ACK);

        // asynchronous reset in the middle of a refund
        step("t6_c100", coin(2'b11), ev(4, 0, 0, 0, 0, 0, 0));
        step("t6_c25",  coin(2'b01), ev(5, 0, 0, 0, 0, 0, 0));
        step("t6_can",  CAN,         ev(4, 0, 0, 1, 0, 0, 1));
        step("t6_low",  NOP,         ev(4, 0, 0, 0, 0, 0, 1));
        #2 reset = 1'b0;
        #1 compare("t6_async_rst", ev(0, 0, 0, 0, 0, 0, 0));
        @(negedge clock);
        reset = 1'b1;
        step("t6_after", NOP,         ev(0, 0, 0, 0, 0, 0, 0));
        step("t6_c25",   coin(2'b01), ev(1, 0, 0, 0, 0, 0, 0));
        step("t6_sel3",  pick(2'd3),  ev(1, 0, 0, 0, 0, 1, 0));
        drain("t6_chg", 1, CAN);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/controlador_vendas.md
# controlador_vendas

Product-selection vending controller that accepts coded coins, keeps the customer credit, sells one of four priced items through a request/acknowledge handshake with the dispenser mechanism, and returns change as a train of 25-cent pulses. It sits between the coin acceptor and the dispenser/coin-return actuators. It generalises the single-price, fixed 150-cent machine into a priced, refunding sequencer.

## Interface
- PRICE0, default 6: price of item 0, in 25-cent units
- PRICE1, default 4: price of item 1, in units
- PRICE2, default 3: price of item 2, in units
- PRICE3, default 5: price of item 3, in units
- MAX_CREDIT, default 12: credit ceiling in units, at most 15
- TIMEOUT_CYCLES, default 1000: idle cycles in CREDIT before an automatic refund, at least 2

- clock  in  1  system clock, all logic on the rising edge
- reset  in  1  asynchronous, active-low
- coin_valid  in  1  one-cycle strobe; A and B are sampled when it is high
- A, B  in  1 each  coin code: 01 = 25 cents (1 unit), 10 = 50 (2), 11 = 100 (4), 00 = invalid
- sel_valid  in  1  one-cycle selection strobe
- sel  in  2  item index
- cancel  in  1  refund request, level sampled
- disp_ack  in  1  dispenser done
- credit  out  4  current credit in units
- disp_req  out  1  dispense request, held until acknowledged
- disp_item  out  2  item being dispensed, valid while disp_req is high
- change_pulse  out  1  one pulse per returned unit
- coin_reject  out  1  one-cycle pulse: the coin is returned to the customer
- sel_denied  out  1  one-cycle pulse: credit is insufficient
- busy  out  1  high in DISPENSE or CHANGE

## Operation
- States: IDLE (credit = 0), CREDIT, DISPENSE, CHANGE.
- All outputs are registered. Every output resets to 0, the state resets to IDLE, and the timeout counter resets to 0.
- Reset mid-operation aborts immediately and discards credit. No refund is issued.
- Priority in IDLE/CREDIT, evaluated in one cycle: cancel, then sel_valid, then coin_valid.
  - A coin_valid coinciding with cancel or sel_valid is rejected.
- Coin handling, in IDLE/CREDIT only:
  - Valid code with credit + value ≤ MAX_CREDIT: credit += value, go to CREDIT.
  - Otherwise (code 00 or overflow): coin_reject pulses and credit is unchanged.
  - Any coin in DISPENSE/CHANGE: coin_reject pulses.
- Selection handling, in IDLE/CREDIT:
  - If credit ≥ PRICE[sel]: credit -= PRICE[sel], disp_item = sel, disp_req = 1, go to DISPENSE.
  - Otherwise: sel_denied pulses and the state is unchanged. A selection in IDLE is always denied when every price is > 0.
  - sel_valid in DISPENSE/CHANGE is ignored, with no pulse.
- Cancel in CREDIT: go to CHANGE. Cancel in IDLE, DISPENSE or CHANGE is ignored.
- DISPENSE: disp_req is held high. disp_ack sampled high clears disp_req, then:
  - credit > 0: go to CHANGE.
  - credit = 0: go to IDLE.
  - disp_ack while not in DISPENSE is ignored.
- CHANGE: change_pulse alternates high/low, one high cycle per unit. Credit decrements in the same cycle the pulse is visible. After the last low cycle with credit = 0, go to IDLE.
- Timeout: the counter runs only in CREDIT and clears on any coin_valid or sel_valid. Reaching TIMEOUT_CYCLES-1 acts as cancel.
- Credit is never negative and never exceeds MAX_CREDIT. Arithmetic is 4-bit unsigned with 5-bit compare headroom.

## Timing
- Input event sampled at edge N → effect visible after edge N (cycle N+1): credit, disp_req, coin_reject, sel_denied.
- Single-cycle pulses are high for exactly one cycle.
- Selection accepted at N: disp_req is high from N+1 until the cycle after disp_ack is sampled.
- Change of k units starting from an event at M (disp_ack or cancel):
  - change_pulse is high at M+1, M+3, …, M+2k−1.
  - credit reads k−1 … 0 in those cycles.
  - IDLE and busy = 0 at M+2k.
- Zero change: IDLE and busy = 0 at M+1.
- Timeout: with no activity after the last event at T, refund pulses start at T+TIMEOUT_CYCLES.
- busy is registered with the state and is high for the full DISPENSE and CHANGE occupancy.

## Test plan
- Coins 50, 50, 25 (credit 5), sel = 1 (price 4) → disp_req and disp_item = 1 next cycle, credit 1. Ack after 3 cycles → one change_pulse, then IDLE with credit 0.
- Coins 100, 100, 100 (credit 12), then a 25 → coin_reject pulse, credit stays 12. An A=B=0 strobe → coin_reject pulse.
- Credit 2, sel = 0 (price 6) → sel_denied pulse, credit stays 2. Then cancel → 2 change_pulses on alternate cycles, IDLE at M+4.
- coin_valid (50) and sel_valid (sel = 2) in the same cycle with credit 3 → sale of item 2, coin_reject pulse, credit 0. After ack → IDLE with no change_pulse.
- Credit 3 with no activity for TIMEOUT_CYCLES → 3 change_pulses; coin during CHANGE → coin_reject; cancel during DISPENSE ignored.
- Reset asserted mid-CHANGE with credit 4 → all outputs 0 asynchronously; after release, state IDLE with credit 0.
